hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall and branch/jump redirect control,
// with saturating performance counters for stall and redirect cycles.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        id_jump,
    input  logic        perf_clear,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RSVD  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        ex_valid_r;
    logic        br_s;
    logic        lu_s;
    logic        stall_inc_s;
    logic        flush_inc_s;
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        sat_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // Hazard detection; ID/EX flush leaves control fields live, so everything is gated by ex_valid_r.
    always_comb begin
        br_s = ex_branch_taken && ex_valid_r;
        lu_s = ex_valid_r && ex_mem_read && (ex_rt != 5'd0) &&
               ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
        stall_inc_s = lu_s && !br_s;
        flush_inc_s = br_s || (id_jump && !lu_s);
    end

    // Prioritised pipeline controls and next recorded action.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_nxt_s = ST_RUN;
        if (br_s) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt_s = ST_FLUSH;
        end else if (lu_s) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            state_nxt_s = ST_STALL;
        end else if (id_jump) begin
            if_id_flush = 1'b1;
            state_nxt_s = ST_FLUSH;
        end else begin
            state_nxt_s = ST_RUN;
        end
    end

    // Recorded action and ID/EX validity tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_RUN;
            ex_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ex_valid_r <= !id_ex_flush;
        end
    end

    // Saturating performance counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else if (perf_clear) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (stall_inc_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (flush_inc_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    assign state     = state_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed literal scenarios plus randomized
// traffic compared every cycle against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs = 5'd0;
    logic [4:0]  id_rt = 5'd0;
    logic        id_uses_rs = 1'b0;
    logic        id_uses_rt = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rt = 5'd0;
    logic        ex_branch_taken = 1'b0;
    logic        id_jump = 1'b0;
    logic        perf_clear = 1'b0;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Model state: whether ID/EX holds a real instruction, last action, counts.
    bit m_ev = 1'b0;
    int m_state = 0;
    int m_stall = 0;
    int m_flush = 0;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .id_jump(id_jump), .perf_clear(perf_clear),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {branch redirect, load-use hazard} for the current inputs.
    function automatic logic [1:0] hz();
        logic b;
        logic l;
        b = ex_branch_taken && m_ev;
        l = m_ev && ex_mem_read && (ex_rt != 5'd0) &&
            ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        return {b, l};
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [1:0] h;
        if (reset) begin
            m_ev    <= 1'b0;
            m_state <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            h = hz();
            m_ev    <= !(h[1] || h[0]);
            m_state <= h[1] ? 2 : (h[0] ? 1 : (id_jump ? 2 : 0));
            if (perf_clear) begin
                m_stall <= 0;
                m_flush <= 0;
            end else begin
                if (h[0] && !h[1] && m_stall < 65535) m_stall <= m_stall + 1;
                if ((h[1] || (id_jump && !h[0])) && m_flush < 65535) m_flush <= m_flush + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] h;
        logic stall_x;
        h = hz();
        stall_x = h[0] && !h[1];
        chk("pc_write",    {31'd0, pc_write},    {31'd0, !stall_x});
        chk("if_id_write", {31'd0, if_id_write}, {31'd0, !stall_x});
        chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, h[1] || (id_jump && !h[0])});
        chk("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, h[1] || h[0]});
        chk("state",       {30'd0, state},       32'(m_state));
        chk("stall_cnt",   {16'd0, stall_cnt},   32'(m_stall));
        chk("flush_cnt",   {16'd0, flush_cnt},   32'(m_flush));
    end

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic mr, input logic [4:0] xrt,
                         input logic bt, input logic j, input logic pc);
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_mem_read = mr; ex_rt = xrt; ex_branch_taken = bt; id_jump = j; perf_clear = pc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with hazardous EX inputs present: controls must stay normal.
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
        chk("rst_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_cnts", {stall_cnt, flush_cnt}, 32'd0);

        next_cycle();
        reset = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("run_pc_write", {31'd0, pc_write}, 32'd1);

        // Load-use: exactly one bubble for the pair.
        next_cycle();
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_stall", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_flush}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("lu_released", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_flush}, 32'hC);
        chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        chk("lu_state", {30'd0, state}, 32'd1);

        // Load into r0 never stalls.
        next_cycle();
        drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("r0_no_stall", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_flush}, 32'hC);

        // Branch and load-use together: branch wins.
        next_cycle();
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("br_lu_ctrl", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_flush}, 32'hF);
        chk("r0_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("stale_br_ignored", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_flush}, 32'hC);
        chk("br_state", {30'd0, state}, 32'd2);
        chk("br_cnts", {stall_cnt, flush_cnt}, {16'd1, 16'd1});

        // Jump alone.
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("jump_ctrl", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_flush}, 32'hE);
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("jump_state", {30'd0, state}, 32'd2);
        chk("jump_flush_cnt", {16'd0, flush_cnt}, 32'd2);

        // Randomized traffic with narrow register ranges to provoke matches.
        for (int i = 0; i < 1500; i++) begin
            next_cycle();
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 49) == 0));
            if ($urandom_range(0, 63) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a stall.
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_stall", {31'd0, pc_write}, 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_state", {30'd0, state}, 32'd0);
        chk("mid_rst_cnts", {stall_cnt, flush_cnt}, 32'd0);
        chk("mid_rst_pc_write", {31'd0, pc_write}, 32'd1);
        #1 reset = 1'b0;

        // Saturate the redirect counter with back-to-back jumps.
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            next_cycle();
        end
        @(negedge clk);
        chk("flush_sat", {16'd0, flush_cnt}, 32'h0000FFFF);

        // Clear overrides a same-cycle stall increment.
        next_cycle();
        drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("clr_stall_ctrl", {31'd0, pc_write}, 32'd0);
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("clr_cnts", {stall_cnt, flush_cnt}, 32'd0);
        chk("clr_state", {30'd0, state}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
